// File: rtl/counter_step_controller_pkg.sv
// Shared types and helpers for the counter step controller.
package step_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_UP,
    PRESS_DN,
    HOLD,
    REPEAT,
    LOCK
  } step_state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } step_dir_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_step_controller_key_debouncer.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one key.
module key_debouncer
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DebounceCycles = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level
);

  localparam int unsigned CntW = width_for(DebounceCycles);

  logic [1:0]      sync;
  logic [CntW-1:0] cnt;

  // Synchronise the raw key, then accept a level change only after
  // DebounceCycles consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], key};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CntW'(DebounceCycles - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/counter_step_controller.sv
// Debounced Up/Down key to step-pulse controller with press-and-hold auto-repeat.
module counter_step_controller #(
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned HoldCycles     = 10,
  parameter int unsigned RepeatCycles   = 3
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyUp,
  input  logic KeyDown,
  output logic Up,
  output logic Down,
  output logic Repeating
);

  import step_ctrl_pkg::*;

  localparam int unsigned TimerMax = (HoldCycles > RepeatCycles) ? HoldCycles : RepeatCycles;
  localparam int unsigned TW       = width_for(TimerMax);
  localparam logic [TW-1:0] HoldLoad   = TW'(HoldCycles - 1);
  localparam logic [TW-1:0] RepeatLoad = TW'(RepeatCycles - 1);

  logic        s_up;
  logic        s_dn;
  logic        held;
  logic        other;
  step_state_t state;
  step_dir_t   dir;
  logic [TW-1:0] timer;

  key_debouncer #(.DebounceCycles(DebounceCycles)) u_deb_up (
    .clk   (Clock),
    .rst_n (Reset),
    .key   (KeyUp),
    .level (s_up)
  );

  key_debouncer #(.DebounceCycles(DebounceCycles)) u_deb_dn (
    .clk   (Clock),
    .rst_n (Reset),
    .key   (KeyDown),
    .level (s_dn)
  );

  // Select the key being stepped and the opposing key for the shared HOLD/REPEAT path.
  always_comb begin
    held  = 1'b0;
    other = 1'b0;
    if (dir == DIR_UP) begin
      held  = s_up;
      other = s_dn;
    end else begin
      held  = s_dn;
      other = s_up;
    end
  end

  // Step FSM with registered pulse and repeat outputs.
  // The hold timer is loaded on entry to PRESS and already counts during PRESS,
  // so the first repeat pulse lands exactly HoldCycles after the first pulse.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      timer     <= '0;
      Up        <= 1'b0;
      Down      <= 1'b0;
      Repeating <= 1'b0;
    end else begin
      Up   <= 1'b0;
      Down <= 1'b0;
      case (state)
        IDLE: begin
          if (s_up && !s_dn) begin
            state <= PRESS_UP;
            dir   <= DIR_UP;
            Up    <= 1'b1;
            timer <= HoldLoad;
          end else if (s_dn && !s_up) begin
            state <= PRESS_DN;
            dir   <= DIR_DN;
            Down  <= 1'b1;
            timer <= HoldLoad;
          end else if (s_up && s_dn) begin
            state <= LOCK;
          end
        end
        PRESS_UP, PRESS_DN: begin
          state <= HOLD;
          timer <= timer - TW'(1);
        end
        HOLD: begin
          if (!held) begin
            state <= IDLE;
          end else if (other) begin
            state <= LOCK;
          end else if (timer == '0) begin
            state     <= REPEAT;
            Repeating <= 1'b1;
            Up        <= (dir == DIR_UP);
            Down      <= (dir == DIR_DN);
            timer     <= RepeatLoad;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        REPEAT: begin
          if (!held) begin
            state     <= IDLE;
            Repeating <= 1'b0;
          end else if (other) begin
            state     <= LOCK;
            Repeating <= 1'b0;
          end else if (timer == '0) begin
            Up    <= (dir == DIR_UP);
            Down  <= (dir == DIR_DN);
            timer <= RepeatLoad;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        LOCK: begin
          if (!s_up && !s_dn) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          Repeating <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_step_controller.sv
// Directed bench for counter_step_controller with a pulse scoreboard.
module tb_counter_step_controller;

  logic Clock   = 1'b0;
  logic Reset   = 1'b0;
  logic KeyUp   = 1'b0;
  logic KeyDown = 1'b0;
  logic Up;
  logic Down;
  logic Repeating;

  typedef struct {
    int   cyc;
    logic up;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t mon_e;
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  counter_step_controller #(
    .DebounceCycles (4),
    .HoldCycles     (10),
    .RepeatCycles   (3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .KeyUp     (KeyUp),
    .KeyDown   (KeyDown),
    .Up        (Up),
    .Down      (Down),
    .Repeating (Repeating)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge Clock);
  endtask

  task automatic push(input int t, input logic up);
    pulse_t e;
    e.cyc = t;
    e.up  = up;
    exp_q.push_back(e);
  endtask

  // Every pulse the DUT produces must match the oldest expected pulse.
  always @(negedge Clock) begin
    if (Up === 1'b1 || Down === 1'b1) begin
      check("no_overlap", 32'(Up & Down), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_at_cycle", cyc, -1);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_dir_up", 32'(Up), 32'(mon_e.up));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // Reset state
    repeat (3) @(negedge Clock);
    check("reset_up", 32'(Up), 0);
    check("reset_down", 32'(Down), 0);
    check("reset_repeating", 32'(Repeating), 0);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    check("idle_up", 32'(Up), 0);
    check("idle_repeating", 32'(Repeating), 0);

    // 1: clean press of 5 cycles
    c = cyc;
    KeyUp = 1'b1;
    push(c + 7, 1'b1);
    wait_to(c + 5);
    KeyUp = 1'b0;
    wait_to(c + 30);
    check("t1_drained", exp_q.size(), 0);

    // 2: bouncing key, then clean press
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      KeyUp = (i % 2 == 0);
      wait_to(c + 2 * i + 2);
    end
    KeyUp = 1'b1;
    push(c + 27, 1'b1);
    wait_to(c + 25);
    KeyUp = 1'b0;
    wait_to(c + 50);
    check("t2_drained", exp_q.size(), 0);

    // 3: KeyDown held, auto-repeat, release collides with timer expiry
    c = cyc;
    KeyDown = 1'b1;
    push(c + 7, 1'b0);
    for (int k = 0; k < 10; k++) push(c + 17 + 3 * k, 1'b0);
    wait_to(c + 16);
    check("t3_rep_before", 32'(Repeating), 0);
    wait_to(c + 17);
    check("t3_rep_start", 32'(Repeating), 1);
    wait_to(c + 40);
    KeyDown = 1'b0;
    wait_to(c + 46);
    check("t3_rep_held", 32'(Repeating), 1);
    wait_to(c + 47);
    check("t3_rep_released", 32'(Repeating), 0);
    wait_to(c + 70);
    check("t3_drained", exp_q.size(), 0);

    // 4: second key during REPEAT locks, release, then a fresh press
    c = cyc;
    KeyUp = 1'b1;
    push(c + 7, 1'b1);
    push(c + 17, 1'b1);
    push(c + 20, 1'b1);
    push(c + 23, 1'b1);
    push(c + 26, 1'b1);
    wait_to(c + 21);
    KeyDown = 1'b1;
    wait_to(c + 27);
    check("t4_rep_before_lock", 32'(Repeating), 1);
    wait_to(c + 28);
    check("t4_rep_locked", 32'(Repeating), 0);
    wait_to(c + 40);
    KeyUp   = 1'b0;
    KeyDown = 1'b0;
    wait_to(c + 55);
    KeyUp = 1'b1;
    push(c + 62, 1'b1);
    wait_to(c + 60);
    KeyUp = 1'b0;
    wait_to(c + 85);
    check("t4_drained", exp_q.size(), 0);

    // 5: both keys together never step
    c = cyc;
    KeyUp   = 1'b1;
    KeyDown = 1'b1;
    wait_to(c + 10);
    check("t5_rep", 32'(Repeating), 0);
    wait_to(c + 15);
    KeyUp   = 1'b0;
    KeyDown = 1'b0;
    wait_to(c + 30);
    check("t5_drained", exp_q.size(), 0);

    // 6: reset during REPEAT with key still held
    c = cyc;
    KeyUp = 1'b1;
    push(c + 7, 1'b1);
    push(c + 17, 1'b1);
    push(c + 20, 1'b1);
    push(c + 23, 1'b1);
    wait_to(c + 22);
    check("t6_rep_before_reset", 32'(Repeating), 1);
    wait_to(c + 23);
    #2 Reset = 1'b0;
    #1;
    check("t6_up_in_reset", 32'(Up), 0);
    check("t6_down_in_reset", 32'(Down), 0);
    check("t6_rep_in_reset", 32'(Repeating), 0);
    wait_to(c + 26);
    #2 Reset = 1'b1;
    push(c + 33, 1'b1);
    push(c + 43, 1'b1);
    push(c + 46, 1'b1);
    push(c + 49, 1'b1);
    push(c + 52, 1'b1);
    wait_to(c + 42);
    check("t6_rep_before", 32'(Repeating), 0);
    wait_to(c + 43);
    check("t6_rep_start", 32'(Repeating), 1);
    wait_to(c + 47);
    KeyUp = 1'b0;
    wait_to(c + 75);
    check("t6_rep_end", 32'(Repeating), 0);
    check("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
